// File: rtl/multicycle_alu_if.sv
// Operand/result bus of multicycle_alu: request channel, result channel and a
// debug view of the controller state.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. While a
// result is offered and not taken, porto and every flag hold their values.
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       aluop;
    logic [WIDTH-1:0] porta;
    logic [WIDTH-1:0] portb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] porto;
    logic             n_flag;
    logic             z_flag;
    logic             v_flag;
    logic             dz_flag;
    logic [1:0]       dbg_state;

    modport master (
        output in_valid, aluop, porta, portb, out_ready,
        input  in_ready, out_valid, porto, n_flag, z_flag, v_flag, dz_flag, dbg_state
    );

    modport slave (
        input  in_valid, aluop, porta, portb, out_ready,
        output in_ready, out_valid, porto, n_flag, z_flag, v_flag, dz_flag, dbg_state
    );
endinterface

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/shift/arithmetic ops plus an iterative
// unsigned multiply (shift-add) and divide (restoring), all outputs registered.
module multicycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    multicycle_alu_if.slave      bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_SLL   = 4'd0;
    localparam logic [3:0] OP_SRL   = 4'd1;
    localparam logic [3:0] OP_SRA   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_NOR   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_SLTU  = 4'd10;
    localparam logic [3:0] OP_MULU  = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REMU  = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_porto;
    logic               r_n_flag;
    logic               r_z_flag;
    logic               r_v_flag;
    logic               r_dz_flag;
    logic [3:0]         r_op;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_is_mc;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_add;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_sc_res;
    logic               w_sc_v;

    logic               w_is_div;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_mc_res;
    logic               w_mc_v;
    logic               w_mc_dz;

    logic [WIDTH-1:0]   w_res;
    logic               w_v;
    logic               w_dz;

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_is_mc  = (bus.aluop >= OP_MULU) && (bus.aluop <= OP_REMU);
    assign w_shamt  = bus.portb[SHAMT_W-1:0];
    assign w_add    = bus.porta + bus.portb;
    assign w_sub    = bus.porta - bus.portb;

    always_comb begin
        w_sc_res = '0;
        w_sc_v   = 1'b0;
        case (bus.aluop)
            OP_SLL:  w_sc_res = bus.porta << w_shamt;
            OP_SRL:  w_sc_res = bus.porta >> w_shamt;
            OP_SRA:  w_sc_res = $unsigned($signed(bus.porta) >>> w_shamt);
            OP_ADD: begin
                w_sc_res = w_add;
                w_sc_v   = (bus.porta[WIDTH-1] == bus.portb[WIDTH-1]) &&
                           (w_add[WIDTH-1] != bus.porta[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_res = w_sub;
                w_sc_v   = (bus.porta[WIDTH-1] != bus.portb[WIDTH-1]) &&
                           (w_sub[WIDTH-1] != bus.porta[WIDTH-1]);
            end
            OP_AND:  w_sc_res = bus.porta & bus.portb;
            OP_OR:   w_sc_res = bus.porta | bus.portb;
            OP_XOR:  w_sc_res = bus.porta ^ bus.portb;
            OP_NOR:  w_sc_res = ~(bus.porta | bus.portb);
            OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.porta) < $signed(bus.portb))};
            OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (bus.porta < bus.portb)};
            default: w_sc_res = '0;
        endcase
    end

    // r_acc holds {high, low}: multiply shifts right adding r_opnd into the
    // high half; divide shifts left with remainder high and quotient low.
    assign w_is_div   = (r_op == OP_DIVU) || (r_op == OP_REMU);
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_opnd};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_opnd});
    assign w_div_rem  = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
    assign w_acc_next = w_is_div ? {w_div_rem, r_acc[WIDTH-2:0], w_div_ge}
                                 : {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide by zero needs no special case: every trial subtract succeeds, so
    // the quotient fills with ones and the remainder accumulates the dividend.
    always_comb begin
        w_mc_res = '0;
        w_mc_v   = 1'b0;
        w_mc_dz  = 1'b0;
        case (r_op)
            OP_MULU: begin
                w_mc_res = w_acc_next[WIDTH-1:0];
                w_mc_v   = |w_acc_next[2*WIDTH-1:WIDTH];
            end
            OP_MULHU: w_mc_res = w_acc_next[2*WIDTH-1:WIDTH];
            OP_DIVU: begin
                w_mc_res = w_acc_next[WIDTH-1:0];
                w_mc_dz  = (r_opnd == '0);
            end
            OP_REMU: begin
                w_mc_res = w_acc_next[2*WIDTH-1:WIDTH];
                w_mc_dz  = (r_opnd == '0);
            end
            default: w_mc_res = '0;
        endcase
    end

    assign w_res = (r_state == S_CALC) ? w_mc_res : w_sc_res;
    assign w_v   = (r_state == S_CALC) ? w_mc_v   : w_sc_v;
    assign w_dz  = (r_state == S_CALC) ? w_mc_dz  : 1'b0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_porto     <= '0;
            r_n_flag    <= 1'b0;
            r_z_flag    <= 1'b1;
            r_v_flag    <= 1'b0;
            r_dz_flag   <= 1'b0;
            r_op        <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= bus.aluop;
                        r_acc      <= {{WIDTH{1'b0}}, bus.porta};
                        r_opnd     <= bus.portb;
                        r_cnt      <= CNT_W'(WIDTH);
                        r_in_ready <= 1'b0;
                        if (w_is_mc) begin
                            r_state <= S_CALC;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_porto     <= w_res;
                            r_n_flag    <= w_res[WIDTH-1];
                            r_z_flag    <= (w_res == '0);
                            r_v_flag    <= w_v;
                            r_dz_flag   <= w_dz;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_porto     <= w_res;
                        r_n_flag    <= w_res[WIDTH-1];
                        r_z_flag    <= (w_res == '0);
                        r_v_flag    <= w_v;
                        r_dz_flag   <= w_dz;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.porto     = r_porto;
    assign bus.n_flag    = r_n_flag;
    assign bus.z_flag    = r_z_flag;
    assign bus.v_flag    = r_v_flag;
    assign bus.dz_flag   = r_dz_flag;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed, table-driven bench for multicycle_alu at WIDTH=32, with hand-written
// sequences for backpressure and reset during an iterative divide.
module tb_multicycle_alu;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    multicycle_alu_if #(.WIDTH(W)) bus ();

    multicycle_alu #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flg;   // {n, z, v, dz}
        int           lat;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] exp_q[$];

    function automatic vec_t mk(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                logic [W-1:0] res, logic [3:0] flg, int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.flg = flg; v.lat = lat;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.n_flag, bus.z_flag, bus.v_flag, bus.dz_flag};
    endfunction

    // Called at a negedge with the unit idle; returns 1 ns after the accept edge.
    task automatic issue(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        bus.in_valid = 1'b1;
        bus.aluop    = op;
        bus.porta    = a;
        bus.portb    = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts negedges until out_valid; in_ready must stay low the whole time.
    task automatic wait_result(output int lat, output logic rdy_ok);
        lat    = 0;
        rdy_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (bus.in_ready) rdy_ok = 1'b0;
            if (bus.out_valid) return;
        end
        errors++;
        $display("FAIL timeout: out_valid never rose within 100 cycles");
        lat = -1;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(vec_t v, int idx);
        int           lat;
        logic         rdy_ok;
        logic [W-1:0] exp_res;
        @(negedge clk);
        chk($sformatf("v%0d_in_ready_idle", idx), bus.in_ready, 1);
        exp_q.push_back(v.res);
        issue(v.op, v.a, v.b);
        wait_result(lat, rdy_ok);
        exp_res = exp_q.pop_front();
        chk($sformatf("v%0d_op%0d_porto", idx, v.op), bus.porto, exp_res);
        chk($sformatf("v%0d_op%0d_flags", idx, v.op), flags_now(), v.flg);
        chk($sformatf("v%0d_op%0d_latency", idx, v.op), lat, v.lat);
        chk($sformatf("v%0d_in_ready_low", idx), rdy_ok, 1);
        release_result();
    endtask

    initial begin
        int   lat;
        logic rdy_ok;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.aluop     = 4'd0;
        bus.porta     = '0;
        bus.portb     = '0;
        bus.out_ready = 1'b0;

        vecs.push_back(mk(4'd3,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1010, 1));
        vecs.push_back(mk(4'd4,  32'h00000005, 32'h00000005, 32'h00000000, 4'b0100, 1));
        vecs.push_back(mk(4'd4,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0010, 1));
        vecs.push_back(mk(4'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100, 1));
        vecs.push_back(mk(4'd2,  32'h80000000, 32'h00000004, 32'hF8000000, 4'b1000, 1));
        vecs.push_back(mk(4'd1,  32'h80000000, 32'h00000004, 32'h08000000, 4'b0000, 1));
        vecs.push_back(mk(4'd0,  32'h00000001, 32'h00000021, 32'h00000002, 4'b0000, 1));
        vecs.push_back(mk(4'd2,  32'h7FFFFFF0, 32'hFFFFFFE4, 32'h07FFFFFF, 4'b0000, 1));
        vecs.push_back(mk(4'd5,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 4'b0000, 1));
        vecs.push_back(mk(4'd6,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 4'b0000, 1));
        vecs.push_back(mk(4'd7,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 4'b0000, 1));
        vecs.push_back(mk(4'd8,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 1));
        vecs.push_back(mk(4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1));
        vecs.push_back(mk(4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100, 1));
        vecs.push_back(mk(4'd15, 32'h00001234, 32'h00005678, 32'h00000000, 4'b0100, 1));
        vecs.push_back(mk(4'd11, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 4'b1010, 33));
        vecs.push_back(mk(4'd12, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 4'b0000, 33));
        vecs.push_back(mk(4'd11, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0110, 33));
        vecs.push_back(mk(4'd12, 32'h00010000, 32'h00010000, 32'h00000001, 4'b0000, 33));
        vecs.push_back(mk(4'd13, 32'd100,      32'd7,        32'd14,       4'b0000, 33));
        vecs.push_back(mk(4'd14, 32'd100,      32'd7,        32'd2,        4'b0000, 33));
        vecs.push_back(mk(4'd13, 32'hFFFFFFFF, 32'd10,       32'h19999999, 4'b0000, 33));
        vecs.push_back(mk(4'd14, 32'hFFFFFFFF, 32'd10,       32'd5,        4'b0000, 33));
        vecs.push_back(mk(4'd13, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 4'b1001, 33));
        vecs.push_back(mk(4'd14, 32'h00001234, 32'h00000000, 32'h00001234, 4'b0001, 33));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_porto", bus.porto, 0);
        chk("reset_flags", flags_now(), 4'b0100);
        chk("reset_state", bus.dbg_state, 0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Backpressure: result and flags hold, new requests are ignored.
        @(negedge clk);
        issue(4'd3, 32'd3, 32'd4);
        wait_result(lat, rdy_ok);
        chk("bp_latency", lat, 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_porto", i), bus.porto, 32'd7);
            chk($sformatf("bp%0d_flags", i), flags_now(), 4'b0000);
            chk($sformatf("bp%0d_out_valid", i), bus.out_valid, 1);
            chk($sformatf("bp%0d_in_ready", i), bus.in_ready, 0);
            bus.in_valid = (i % 2 == 0);
            bus.aluop    = 4'd4;
            bus.porta    = 32'd100;
            bus.portb    = 32'd1;
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        chk("bp_hold_porto", bus.porto, 32'd7);
        release_result();
        @(negedge clk);
        chk("bp_next_in_ready", bus.in_ready, 1);
        chk("bp_next_out_valid", bus.out_valid, 0);
        issue(4'd4, 32'd10, 32'd3);
        wait_result(lat, rdy_ok);
        chk("bp_next_porto", bus.porto, 32'd7);
        chk("bp_next_latency", lat, 1);
        release_result();

        // Reset in the 10th CALC cycle of a divide discards it.
        @(negedge clk);
        issue(4'd13, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        chk("rst_mid_calc_state", bus.dbg_state, 1);
        chk("rst_mid_calc_in_ready", bus.in_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_calc_state", bus.dbg_state, 0);
        chk("rst_calc_in_ready", bus.in_ready, 1);
        chk("rst_calc_out_valid", bus.out_valid, 0);
        chk("rst_calc_porto", bus.porto, 0);
        chk("rst_calc_flags", flags_now(), 4'b0100);
        issue(4'd3, 32'd1, 32'd1);
        wait_result(lat, rdy_ok);
        chk("rst_fresh_add_porto", bus.porto, 32'd2);
        chk("rst_fresh_add_latency", lat, 1);
        release_result();

        // No stray result may appear from the discarded divide.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                errors++;
                $display("FAIL stray_result: out_valid=1 at idle cycle %0d, expected 0", i);
                break;
            end
        end
        checks++;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Width is generic (WIDTH). Adds arithmetic right shift and an iterative unsigned multiply/divide unit.
- Operand/result transfer uses a valid/ready handshake, and all outputs are registered.
- Sits in the execute stage. The hazard unit stalls the pipeline while in_ready is low.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and a power of two.
- SHAMT_W, $clog2(WIDTH), derived; shift-amount bits taken from portb.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- aluop  in  4  opcode: 0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, 10 SLTU, 11 MULU (low half), 12 MULHU (high half), 13 DIVU, 14 REMU, 15 reserved.
- porta  in  WIDTH  operand A.
- portb  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- porto  out  WIDTH  result.
- n_flag  out  1  porto[WIDTH-1].
- z_flag  out  1  porto == 0.
- v_flag  out  1  overflow (see below).
- dz_flag  out  1  divide by zero on DIVU/REMU.

Behaviour:
- FSM states and transitions:
  - IDLE → DONE on accept of a single-cycle op (0-10, 15).
  - IDLE → CALC on accept of ops 11-14.
  - CALC → DONE after exactly WIDTH iteration cycles.
  - DONE → IDLE when out_ready=1.
- Accept = in_valid && in_ready. in_ready = (state==IDLE). Operands and aluop are captured at the accept edge. Inputs are ignored in all other states.
- Latency: accept in cycle c.
  - Single-cycle op: out_valid=1 in cycle c+1.
  - Multi-cycle op: CALC occupies c+1..c+WIDTH; out_valid=1 in cycle c+WIDTH+1.
- Handshake:
  - out_valid = (state==DONE).
  - porto and all flags are held stable while out_valid=1 && out_ready=0.
  - The result transfers on the edge where out_valid && out_ready. The next request can be accepted the following cycle, so peak throughput is one op per 2 cycles.
- Shifts:
  - Shift amount = portb[SHAMT_W-1:0]; upper portb bits are ignored.
  - SRA replicates porta[WIDTH-1]. SLL and SRL zero-fill.
- ADD/SUB: two's-complement, wraps mod 2^WIDTH.
  - ADD: v_flag=1 iff operand signs are equal and the result sign differs.
  - SUB: v_flag=1 iff operand signs differ and the result sign differs from porta.
- SLT/SLTU: porto = {WIDTH-1 zeros, compare bit}; signed and unsigned compare respectively.
- Multiply: radix-2 shift-add, one partial product per CALC cycle, 2*WIDTH-bit accumulator.
  - MULU returns the low half; v_flag=1 iff the high half ≠ 0.
  - MULHU returns the high half; v_flag=0.
- Divide: restoring, one quotient bit per CALC cycle.
  - DIVU returns the quotient; REMU returns the remainder.
  - portb==0: quotient = all ones, remainder = porta, dz_flag=1. The op still takes the full WIDTH cycles.
- v_flag=0 and dz_flag=0 for all ops not listed above.
- n_flag and z_flag are derived from the registered porto for every op.
- Reserved opcode 15: porto=0, z_flag=1, other flags 0, single-cycle.
- Reset: RST=1 at any edge, including mid-CALC or in DONE, puts the FSM in IDLE and discards the in-flight op. Following that edge:
  - in_ready=1, out_valid=0.
  - porto=0, n_flag=0, z_flag=1, v_flag=0, dz_flag=0.
  - Iteration counter=0.
- The iteration counter is $clog2(WIDTH)+1 bits wide, loaded at accept and decremented in CALC. The FSM exits CALC on the cycle the counter reaches 1.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF + 0x00000001 → porto=0x80000000, v=1, n=1, z=0, out_valid exactly 1 cycle after accept; SUB 5-5 → 0, z=1, v=0.
- SRA 0x80000000 by 4 → 0xF8000000; SRL same → 0x08000000; SLL 0x1 by portb=33 → 0x00000002 (amount 1).
- MULU 0xFFFFFFFF × 2 → 0xFFFFFFFE, v=1; MULHU same operands → 0x00000001, v=0. out_valid exactly 33 cycles after accept, in_ready low throughout.
- DIVU 100/7 → 14, REMU 100/7 → 2; DIVU 0x1234/0 → 0xFFFFFFFF, dz=1; REMU 0x1234/0 → 0x1234, dz=1.
- Backpressure: ADD 3+4 with out_ready=0 for 5 cycles → porto=7 and flags stable, in_valid pulses ignored. Then out_ready=1 for 1 cycle, and the next op is accepted the cycle after.
- RST=1 at CALC cycle 10 of DIVU → next cycle state IDLE, in_ready=1, out_valid=0, porto=0, z=1. A fresh ADD 1+1 then returns 2 after 1 cycle.
